// File: rtl/instr_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch_pkg
// Brief    : Field positions and fetch-FSM encodings shared by the fetch unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_fetch_pkg;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 11;
  localparam int RD_HI     = 10;
  localparam int RD_LO     = 8;
  localparam int RS_HI     = 7;
  localparam int RS_LO     = 5;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;

  localparam int FSTATE_BITS = 1;

  typedef enum logic [FSTATE_BITS-1:0] {
    FSTATE_IDLE = 1'b0,
    FSTATE_WAIT = 1'b1
  } fstate_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_instr_reg.sv
//------------------------------------------------------------------------------
// Module   : instr_reg
// Brief    : Instruction register with fixed-position field decode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_reg
  import instr_fetch_pkg::*;
#(
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] data,
  output logic [4:0]             opcode,
  output logic [2:0]             rd,
  output logic [2:0]             rs,
  output logic [7:0]             imm
);

  logic [INSTR_WIDTH-1:0] r_ir;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ir <= '0;
    end else if (load) begin
      r_ir <= data;
    end
  end

  // rs and imm overlap by design; bits above 15 are kept but never decoded
  assign opcode = r_ir[OPCODE_HI:OPCODE_LO];
  assign rd     = r_ir[RD_HI:RD_LO];
  assign rs     = r_ir[RS_HI:RS_LO];
  assign imm    = r_ir[IMM_HI:IMM_LO];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch
// Brief    : Fetch unit: PC, branch mux, two-state memory handshake FSM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   control_instruction,
  input  logic                   branch_en,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ready,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [4:0]             opcode,
  output logic [2:0]             rd,
  output logic [2:0]             rs,
  output logic [7:0]             imm,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   stall,
  output logic                   fetch_done
);

  localparam logic [ADDR_WIDTH-1:0] c_pc_rst = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] c_one    = ADDR_WIDTH'(1);

  fstate_t               r_state;
  fstate_t               w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] w_eff_addr;
  logic                  w_accept;
  logic                  r_fetch_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= FSTATE_IDLE;
      r_pc         <= c_pc_rst;
      r_fetch_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_fetch_done <= w_accept;
    end
  end

  // While waiting, r_pc holds the in-flight address so mem_addr stays stable
  always_comb begin
    w_eff_addr  = branch_en ? branch_target : r_pc;
    mem_req     = 1'b0;
    mem_addr    = r_pc;
    w_accept    = 1'b0;
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (reset) begin
      case (r_state)
        FSTATE_IDLE: begin
          mem_addr = w_eff_addr;
          if (control_instruction) begin
            mem_req = 1'b1;
            if (mem_ready) begin
              w_accept = 1'b1;
              w_pc_nxt = w_eff_addr + c_one;
            end else begin
              w_pc_nxt    = w_eff_addr;
              w_state_nxt = FSTATE_WAIT;
            end
          end else if (branch_en) begin
            w_pc_nxt = branch_target;
          end
        end
        FSTATE_WAIT: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            w_accept    = 1'b1;
            w_pc_nxt    = r_pc + c_one;
            w_state_nxt = FSTATE_IDLE;
          end
        end
        default: begin
          w_state_nxt = FSTATE_IDLE;
        end
      endcase
    end
  end

  assign pc         = r_pc;
  assign stall      = (r_state == FSTATE_WAIT);
  assign fetch_done = r_fetch_done;

  instr_reg #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_instr_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (w_accept),
    .data   (mem_rdata),
    .opcode (opcode),
    .rd     (rd),
    .rs     (rs),
    .imm    (imm)
  );

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting opposite the multicycle control FSM. It answers the controller's `control_instruction` strobe by reading program memory at the current PC, latching the word into the instruction register, and advancing the PC. It presents the decoded fields (`opcode`, register indices, immediate) back to the controller and datapath. On a slow memory it raises `stall` so the controller holds in FETCH.

## Interface
- `ADDR_WIDTH`, 8: PC / program-memory address width.
- `INSTR_WIDTH`, 16: instruction word width; minimum 16.
- `RESET_PC`, 0: PC value after reset.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on `clk` rising edge.
- `control_instruction`  in  1  fetch strobe from the control FSM, one cycle wide.
- `branch_en`  in  1  load PC from `branch_target`.
- `branch_target`  in  ADDR_WIDTH  new PC value.
- `mem_req`  out  1  program-memory read request.
- `mem_addr`  out  ADDR_WIDTH  read address.
- `mem_ready`  in  1  read data valid this cycle.
- `mem_rdata`  in  INSTR_WIDTH  read data.
- `opcode`  out  5  IR[15:11].
- `rd`  out  3  IR[10:8].
- `rs`  out  3  IR[7:5].
- `imm`  out  8  IR[7:0], zero-extended by the consumer.
- `pc`  out  ADDR_WIDTH  current PC, which is the address of the next fetch.
- `stall`  out  1  fetch outstanding; the controller must not leave FETCH.
- `fetch_done`  out  1  one-cycle pulse: IR updated this cycle.

## Operation
- The FSM has two states.
  - IDLE, the reset state.
  - WAIT, a fetch issued but not yet answered.
- IDLE, `control_instruction`=1:
  - `mem_req`=1 combinationally; `mem_addr` = branch-resolved PC (see below).
  - If `mem_ready`=1 at that edge: IR <= `mem_rdata`, PC <= addr+1, `fetch_done` pulses next cycle, stay in IDLE.
  - Otherwise go to WAIT.
- WAIT:
  - `mem_req`=1, `mem_addr` held constant, `stall`=1.
  - On an edge with `mem_ready`=1: latch IR, PC <= addr+1, `fetch_done` pulses, go to IDLE.
- Branch resolution, sampled in IDLE only:
  - With `branch_en`=1, the effective address is `branch_target`.
  - If `control_instruction` is also 1 in that cycle, the fetch uses `branch_target` and PC <= `branch_target`+1.
  - Without a fetch, PC <= `branch_target`.
  - `branch_en` in WAIT is ignored.
- `control_instruction` in WAIT is ignored; a second fetch is never queued.
- PC increment wraps modulo 2^ADDR_WIDTH: all-ones+1 = 0, and no flag is raised.
- IR bits above [15:0] (for INSTR_WIDTH>16) are stored but not decoded.
- `mem_rdata` is sampled only on an accepting edge; at any other time its value is don't-care.

## Timing
- Reset values (`reset`=0 at an edge):
  - state=IDLE, PC=RESET_PC, IR=0 (`opcode`=0, `rd`=`rs`=`imm`=0).
  - `stall`=0, `fetch_done`=0.
  - `mem_req` is forced to 0 while `reset`=0, regardless of `control_instruction`.
- A reset asserted in WAIT abandons the fetch. A `mem_ready` arriving in the same cycle is discarded, and PC does not advance.
- Zero-wait memory (`mem_ready` tied 1): decoded fields are valid in the cycle after the strobe, i.e. in the controller's DECODE state. Latency is 1 cycle.
- With N wait cycles (`mem_ready` first high N cycles after the strobe):
  - `stall` is high for N cycles starting the cycle after the strobe.
  - IR is updated at the edge where `mem_ready` is sampled high.
  - Fields are valid N+1 cycles after the strobe.
- `stall` is registered (state==WAIT). `mem_req`/`mem_addr` are combinational from state, strobe, and branch inputs.
- IR and decoded fields hold between fetches; `fetch_done` is 0 except for the single pulse cycle.

## Structure
- The shared include `parameters.v` gains these constants, alongside the existing `INSTR_*`/`OP_*`/`STATE_*`:
  - Field positions: `OPCODE_HI`=15, `OPCODE_LO`=11, `RD_HI`/`RD_LO`, `RS_HI`/`RS_LO`, `IMM_HI`/`IMM_LO`.
  - Fetch state encodings: `FSTATE_IDLE`, `FSTATE_WAIT`, with `FSTATE_BITS`.
- The natural sub-module is `instr_reg`: the IR plus the field decode (pure slice). It takes a load enable, the data, and the synchronous active-low reset. The top level keeps the FSM, PC and branch mux.

## Test plan
- Reset then zero-wait fetch, with mem[0]=16'h0A45: strobe at cycle 1 -> `mem_addr`=0, `mem_req`=1. Cycle 2 shows `opcode`=5'h01, `rd`=2, `rs`=2, `imm`=8'h45, `pc`=1, `fetch_done`=1.
- 3 wait states: strobe, `mem_ready` high on the 4th cycle -> `stall`=1 for 3 cycles, `mem_addr` stable, IR updated once, `pc`+1, one `fetch_done` pulse.
- Wrap: PC=8'hFF, fetch -> `mem_addr`=8'hFF, then `pc`=8'h00.
- Branch plus strobe in the same cycle, `branch_target`=8'h20 -> `mem_addr`=8'h20, `pc`=8'h21. `branch_en` during WAIT -> `pc` unaffected.
- Reset (`reset`=0) in WAIT, with `mem_ready`=1 in the same cycle -> IR=0, `pc`=RESET_PC, `stall`=0, no `fetch_done`, `mem_req`=0.
- Strobe during WAIT -> ignored: exactly one memory transaction and one `fetch_done`.
